// File: rtl/dmem_responder_pkg.sv
// Shared constants for the miss-service responder: FSM encoding, default
// geometry and the latency counter width.
package dmem_responder_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEF_LATENCY = 4;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STATE_W     = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WR_BUSY   = 3'd1;
  localparam state_t ST_WR_ACK    = 3'd2;
  localparam state_t ST_WAIT_WCLR = 3'd3;
  localparam state_t ST_RD_BUSY   = 3'd4;
  localparam state_t ST_RD_ACK    = 3'd5;

  // Counter reload value: the busy states count LATENCY-1 down to 0.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port word array: one shared port, synchronous write and
// synchronous read. Only the read-data register is reset; the array is not.
module mem_sram_1p
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read register: loads only on a read access, otherwise holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               rdata_q <= '0;
    else if (en_i && !we_i)    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Miss-service responder: optional dirty-victim writeback followed by a
// refill read, each taking LATENCY cycles and ending in a one-cycle
// rsp_valid pulse. A level-held request is served once per address.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        request_valid,
  input  logic [31:0] addr,
  input  logic        w_valid,
  input  logic [31:0] w_addr,
  input  logic [31:0] w_data,
  output logic        rsp_valid,
  output logic [31:0] r_data
);

  localparam logic [CNT_W-1:0] CNT_LOAD = lat_load(LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              served_q, served_d;
  logic [31:0]       addr_q, addr_d;
  logic [ADDR_W-1:0] w_idx_q, w_idx_d;
  logic [31:0]       w_data_q, w_data_d;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;

  // Next-state logic for the FSM, latency counter and latched request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    w_idx_d  = w_idx_q;
    w_data_d = w_data_q;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (request_valid && !served_q) begin
          addr_d   = addr;
          w_idx_d  = w_addr[ADDR_W+1:2];
          w_data_d = w_data;
          cnt_d    = CNT_LOAD;
          state_d  = w_valid ? ST_WR_BUSY : ST_RD_BUSY;
        end
      end
      ST_WR_BUSY: begin
        if (cnt_q == '0) begin
          mem_en  = 1'b1;
          mem_we  = 1'b1;
          state_d = ST_WR_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_ACK: state_d = ST_WAIT_WCLR;
      ST_WAIT_WCLR: begin
        if (!w_valid) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_RD_BUSY;
        end
      end
      ST_RD_BUSY: begin
        if (cnt_q == '0) begin
          mem_en  = 1'b1;
          state_d = ST_RD_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_ACK: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Served flag blocks re-accepting a level-held request for the same addr.
  always_comb begin
    served_d = served_q;
    if (state_q == ST_RD_ACK)                     served_d = 1'b1;
    else if (!request_valid || (addr != addr_q))  served_d = 1'b0;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      served_q <= 1'b0;
      addr_q   <= '0;
      w_idx_q  <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
      addr_q   <= addr_d;
      w_idx_q  <= w_idx_d;
      w_data_q <= w_data_d;
    end
  end

  assign mem_addr  = (state_q == ST_WR_BUSY) ? w_idx_q : addr_q[ADDR_W+1:2];
  assign rsp_valid = (state_q == ST_WR_ACK) || (state_q == ST_RD_ACK);

  mem_sram_1p #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (w_data_q),
    .rdata_o (r_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=4 instance and one
// LATENCY=1 instance driven by the same stimulus.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        CLK;
  logic        RESET;
  logic        request_valid;
  logic [31:0] addr;
  logic        w_valid;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        rsp0, rsp1;
  logic [31:0] rdat0, rdat1;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.LATENCY(4)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .request_valid(request_valid), .addr(addr),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .rsp_valid(rsp0), .r_data(rdat0)
  );

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .request_valid(request_valid), .addr(addr),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .rsp_valid(rsp1), .r_data(rdat1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Launch a request in the current cycle (cycle 0) and watch one instance.
  // w_valid is held for 'hold' cycles after the write ack, then dropped.
  task automatic txn(input bit sel, input logic wv, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [31:0] a,
                     input int hold, input bit keep,
                     output int np, output int ack_c, output int rd_c,
                     output logic [31:0] rd);
    int c;
    logic p;
    logic [31:0] d;
    request_valid = 1'b1; addr = a; w_valid = wv; w_addr = wa; w_data = wd;
    np = 0; ack_c = -1; rd_c = -1; rd = '0; c = 0;
    while (c < 60 && !(rd_c >= 0 && c >= rd_c + 3)) begin
      step();
      c++;
      p = sel ? rsp1 : rsp0;
      d = sel ? rdat1 : rdat0;
      if (p) begin
        np++;
        if (wv && ack_c < 0) ack_c = c;
        else if (rd_c < 0) begin
          rd_c = c;
          rd   = d;
        end
      end
      if (wv && ack_c >= 0 && c >= ack_c + 1 + hold) w_valid = 1'b0;
    end
    if (!keep) begin
      request_valid = 1'b0;
      step();
    end
  endtask

  int          np, ack_c, rd_c, got, extra;
  logic [31:0] rd, dat;

  initial begin
    RESET = 1'b1; request_valid = 1'b0; addr = '0;
    w_valid = 1'b0; w_addr = '0; w_data = '0;
    #1 RESET = 1'b0;
    #2;
    chk("reset_rsp_valid", {31'd0, rsp0}, 32'd0);
    chk("reset_r_data", rdat0, 32'd0);
    chk("reset_state", {29'd0, u_dut0.state_q}, {29'd0, ST_IDLE});
    step(); step();
    RESET = 1'b1;
    step();

    // Preload array[5] via writeback; read of 0x300 is not checked.
    txn(0, 1'b1, 32'h14, 32'hDEADBEEF, 32'h300, 0, 0, np, ack_c, rd_c, rd);
    chk("preA_ack_cycle", 32'(ack_c), 32'd5);
    chk("preA_rd_cycle", 32'(rd_c), 32'd11);
    chk("preA_pulses", 32'(np), 32'd2);

    // Preload array[32]; refill of index 5 returns the earlier write.
    txn(0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h14, 0, 0, np, ack_c, rd_c, rd);
    chk("preB_rd_data", rd, 32'hDEADBEEF);

    // Clean read of addr 0x14.
    txn(0, 1'b0, 32'h0, 32'h0, 32'h14, 0, 0, np, ack_c, rd_c, rd);
    chk("clean_rd_cycle", 32'(rd_c), 32'd5);
    chk("clean_pulses", 32'(np), 32'd1);
    chk("clean_rd_data", rd, 32'hDEADBEEF);
    chk("clean_r_data_hold", rdat0, 32'hDEADBEEF);

    // Writeback to 0x40 then refill of 0x80.
    txn(0, 1'b1, 32'h40, 32'h12345678, 32'h80, 0, 0, np, ack_c, rd_c, rd);
    chk("wb_ack_cycle", 32'(ack_c), 32'd5);
    chk("wb_rd_cycle", 32'(rd_c), 32'd11);
    chk("wb_rd_data", rd, 32'hCAFEF00D);

    // Request dropped and inputs changed right after accept: still completes.
    request_valid = 1'b1; addr = 32'h40; w_valid = 1'b0;
    step();
    request_valid = 1'b0; addr = 32'h14; w_data = '0;
    got = -1; extra = 0; dat = '0;
    for (int c = 2; c <= 25; c++) begin
      step();
      if (rsp0) begin
        if (got < 0) begin
          got = c;
          dat = rdat0;
        end else extra++;
      end
    end
    chk("drop_rd_cycle", 32'(got), 32'd5);
    chk("drop_rd_data", dat, 32'h12345678);
    chk("drop_extra_pulses", 32'(extra), 32'd0);

    // Aliasing: bits [1:0] and above bit 11 are ignored -> index 5.
    txn(0, 1'b0, 32'h0, 32'h0, 32'h1017, 0, 0, np, ack_c, rd_c, rd);
    chk("alias_rd_data", rd, 32'hDEADBEEF);

    // Same-index writeback and refill.
    txn(0, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h100, 0, 0, np, ack_c, rd_c, rd);
    chk("raw_rd_cycle", 32'(rd_c), 32'd11);
    chk("raw_rd_data", rd, 32'hA5A5A5A5);

    // Level-held request is served once; new addr starts a new transaction.
    txn(0, 1'b0, 32'h0, 32'h0, 32'h14, 0, 1, np, ack_c, rd_c, rd);
    chk("held_rd_cycle", 32'(rd_c), 32'd5);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (rsp0) extra++;
    end
    chk("held_no_repeat", 32'(extra), 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 32'h200, 0, 0, np, ack_c, rd_c, rd);
    chk("newaddr_rd_cycle", 32'(rd_c), 32'd6);
    chk("newaddr_pulses", 32'(np), 32'd1);

    // Reset during RD_BUSY abandons the read.
    request_valid = 1'b1; addr = 32'h14; w_valid = 1'b0;
    step(); step();
    RESET = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp0}, 32'd0);
    chk("midrst_state", {29'd0, u_dut0.state_q}, {29'd0, ST_IDLE});
    chk("midrst_r_data", rdat0, 32'd0);
    request_valid = 1'b0;
    step(); step();
    RESET = 1'b1;
    step();
    txn(0, 1'b0, 32'h0, 32'h0, 32'h14, 0, 0, np, ack_c, rd_c, rd);
    chk("postrst_rd_cycle", 32'(rd_c), 32'd5);
    chk("postrst_rd_data", rd, 32'hDEADBEEF);

    // LATENCY=1: w_valid held 2 cycles past the ack -> 3 WAIT_WCLR cycles.
    txn(1, 1'b1, 32'h8, 32'h0BADCAFE, 32'h8, 2, 0, np, ack_c, rd_c, rd);
    chk("l1_ack_cycle", 32'(ack_c), 32'd2);
    chk("l1_rd_cycle", 32'(rd_c), 32'd7);
    chk("l1_pulses", 32'(np), 32'd2);
    chk("l1_rd_data", rd, 32'h0BADCAFE);

    repeat (12) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from the start of a memory access to its completion; legal range 1..15.
REQ-002 Parameter ADDR_W, default 10: word-index width; the array holds 2^ADDR_W 32-bit words.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 RESET  input  1  reset, asynchronous, active-low.
REQ-005 request_valid  input  1  level: a miss-service request is pending.
REQ-006 addr  input  32  byte address of the refill read.
REQ-007 w_valid  input  1  level: a dirty-victim writeback must precede the read.
REQ-008 w_addr  input  32  byte address of the writeback.
REQ-009 w_data  input  32  writeback data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse, for both the write ack and the read data.
REQ-011 r_data  output  32  read data; meaningful only in the rsp_valid cycle that ends a read.

Function
REQ-012 Array index SHALL be byte address bits [ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 SHALL be ignored, so addresses alias modulo the array size.
REQ-013 FSM states SHALL be IDLE, WR_BUSY, WR_ACK, WAIT_WCLR, RD_BUSY, RD_ACK.
REQ-014 IDLE -> accept when request_valid=1 and served=0; go to WR_BUSY if w_valid=1, otherwise RD_BUSY; load the latency counter with LATENCY-1 on entry.
REQ-015 served flag: set on RD_ACK; cleared when request_valid=0, or when addr differs from the addr latched at accept.
REQ-016 addr, w_addr and w_data SHALL be latched at accept; input changes after accept SHALL NOT affect the transaction in flight.
REQ-017 WR_BUSY: decrement the counter each cycle; at 0, write w_data to the array and go to WR_ACK.
REQ-018 WR_ACK: rsp_valid=1 for exactly one cycle, then go to WAIT_WCLR.
REQ-019 WAIT_WCLR: remain until w_valid=0, then go to RD_BUSY with the counter loaded to LATENCY-1.
REQ-020 RD_BUSY: decrement the counter each cycle; at 0, issue a synchronous array read of the latched addr and go to RD_ACK.
REQ-021 RD_ACK: rsp_valid=1 for exactly one cycle with r_data = array word, then go to IDLE.
REQ-022 Read-after-write to the same index within one transaction SHALL return the newly written w_data.
REQ-023 Total latency from accept to read rsp_valid: LATENCY+1 cycles without writeback; with writeback, 2*(LATENCY+1) cycles plus the cycles spent in WAIT_WCLR.
REQ-024 r_data SHALL hold its last value outside RD_ACK; rsp_valid SHALL be 0 in every state except WR_ACK and RD_ACK.
REQ-025 If request_valid drops mid-transaction, the transaction SHALL still complete; no abort.

Reset
REQ-026 On RESET=0: state=IDLE, counter=0, served=0, rsp_valid=0, r_data=0, latched registers=0.
REQ-027 Reset mid-transaction SHALL abandon it; a write is committed only if the array write edge has already occurred.
REQ-028 Array contents SHALL NOT be reset.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the default LATENCY and ADDR_W, and the width constant CNT_W=4.
REQ-030 The storage SHALL be a sub-module, mem_sram_1p: a single-port array with synchronous write and synchronous read, one port shared by write and read.

Verification
REQ-031 Clean read, LATENCY=4: array[5]=0xDEADBEEF, request addr=0x14 with w_valid=0 -> single rsp_valid 5 cycles after accept, r_data=0xDEADBEEF.
REQ-032 Writeback then read: w_valid=1, w_addr=0x40, w_data=0x12345678, addr=0x80 -> ack pulse at cycle 5; w_valid dropped 1 cycle later; read pulse returns array[32]; array[16]=0x12345678.
REQ-033 Same-index writeback and refill: w_addr=addr=0x100, w_data=0xA5A5A5A5 -> read r_data=0xA5A5A5A5.
REQ-034 Level-held request: request_valid stays 1 with the same addr after completion -> no second transaction; changing addr to 0x200 -> new transaction accepted.
REQ-035 Reset asserted during RD_BUSY -> rsp_valid=0 and state=IDLE immediately; after release, a re-request completes normally.
REQ-036 LATENCY=1 and w_valid held high for 3 cycles after the write ack -> exactly 3 WAIT_WCLR cycles, no spurious rsp_valid.
